// File: rtl/e203_ifu_pcgen.sv
// e203_ifu_pcgen -- IFU fetch-PC generator and fetch-request sequencer.
//   Picks the next fetch address from one of three sources. In priority order these are the
//   EXU flush operands, the BPU predicted-taken operands, and the sequential +2/+4 increment.
//   Issues one fetch per instruction and passes live responses on to the IR. Responses that a
//   flush has made stale are dropped. The PC of the last issued fetch goes back to the BPU.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   dec_i_valid/dec_is_rv32        decode handshake and instruction length
//   bpu_wait, prdt_*               BPU stall and predicted-target operands
//   pipe_flush_req/_add_op*/_ack   EXU redirect and its target operands, acked in the same cycle
//   halt_req/halt_ack              quiesce handshake
//   ifu_req_*                      fetch request to the ITCM/BIU
//   ifu_rsp_*                      fetch response from the ITCM/BIU
//   ir_ready, ifu_o_valid/_err     response delivery to the IR
//   pc                             PC of the last issued fetch
module e203_ifu_pcgen #(
  parameter int                  PC_SIZE    = 32,
  parameter logic [PC_SIZE-1:0]  RESET_PC   = 32'h8000_0000,
  parameter int                  OUTS_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               dec_i_valid,
  input  logic               dec_is_rv32,
  input  logic               bpu_wait,
  input  logic               prdt_taken,
  input  logic [PC_SIZE-1:0] prdt_pc_add_op1,
  input  logic [PC_SIZE-1:0] prdt_pc_add_op2,
  input  logic               pipe_flush_req,
  input  logic [PC_SIZE-1:0] pipe_flush_add_op1,
  input  logic [PC_SIZE-1:0] pipe_flush_add_op2,
  output logic               pipe_flush_ack,
  input  logic               halt_req,
  output logic               halt_ack,
  output logic               ifu_req_valid,
  input  logic               ifu_req_ready,
  output logic [PC_SIZE-1:0] ifu_req_pc,
  input  logic               ifu_rsp_valid,
  output logic               ifu_rsp_ready,
  input  logic               ifu_rsp_err,
  input  logic               ir_ready,
  output logic               ifu_o_valid,
  output logic               ifu_o_err,
  output logic [PC_SIZE-1:0] pc
);

  localparam logic [1:0] OUTS_MAX = 2'(OUTS_DEPTH);

  logic               pend_q, pend_d;
  logic [PC_SIZE-1:0] pend_pc_q, pend_pc_d;
  logic [PC_SIZE-1:0] pc_r_q, pc_r_d;
  logic [1:0]         outs_cnt_q, outs_cnt_d;
  logic [1:0]         drop_cnt_q, drop_cnt_d;
  logic               halt_ack_q, halt_ack_d;

  logic               dec_acc, outs_nz, drop, req_hs, rsp_hs;
  logic [PC_SIZE-1:0] add_a, add_b, add_sum, pc_nxt;

  always_comb begin
    dec_acc = dec_i_valid & ~bpu_wait & ~pipe_flush_req;
    outs_nz = (outs_cnt_q != 2'd0);
    drop    = (drop_cnt_q != 2'd0);

    // One shared adder, with the operands picked by priority.
    add_a = pc_r_q;
    add_b = dec_is_rv32 ? PC_SIZE'(4) : PC_SIZE'(2);
    if (pipe_flush_req) begin
      add_a = pipe_flush_add_op1;
      add_b = pipe_flush_add_op2;
    end else if (prdt_taken) begin
      add_a = prdt_pc_add_op1;
      add_b = prdt_pc_add_op2;
    end
    add_sum = add_a + add_b;
    pc_nxt  = {add_sum[PC_SIZE-1:1], 1'b0};

    ifu_req_valid  = ~rst & pend_q & ~halt_req & (outs_cnt_q < OUTS_MAX);
    ifu_req_pc     = rst ? RESET_PC : pend_pc_q;
    // Stale responses are drained even when the IR cannot take them.
    ifu_rsp_ready  = ~rst & outs_nz & (drop | ir_ready);
    ifu_o_valid    = ~rst & ifu_rsp_valid & outs_nz & ~drop;
    ifu_o_err      = ifu_rsp_err & ifu_o_valid;
    pipe_flush_ack = ~rst & pipe_flush_req;
    halt_ack       = ~rst & halt_ack_q;
    pc             = rst ? RESET_PC : pc_r_q;

    req_hs = ifu_req_valid & ifu_req_ready;
    rsp_hs = ifu_rsp_valid & ifu_rsp_ready;

    outs_cnt_d = outs_cnt_q + {1'b0, req_hs} - {1'b0, rsp_hs};

    // A flush makes every fetch still in flight stale. That includes a fetch whose request
    // handshakes in this same cycle, because it carries the old pend_pc.
    drop_cnt_d = drop_cnt_q;
    if (pipe_flush_req)     drop_cnt_d = outs_cnt_d;
    else if (rsp_hs & drop) drop_cnt_d = drop_cnt_q - 2'd1;

    // A flush that arrives before the owed fetch issues simply overwrites its address.
    pend_d    = pend_q;
    pend_pc_d = pend_pc_q;
    if (pipe_flush_req | dec_acc) begin
      pend_d    = 1'b1;
      pend_pc_d = pc_nxt;
    end else if (req_hs) begin
      pend_d    = 1'b0;
    end

    pc_r_d     = req_hs ? pend_pc_q : pc_r_q;
    halt_ack_d = halt_req & ~req_hs & ~outs_nz;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q     <= 1'b1;
      pend_pc_q  <= RESET_PC;
      pc_r_q     <= RESET_PC;
      outs_cnt_q <= 2'd0;
      drop_cnt_q <= 2'd0;
      halt_ack_q <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      pend_pc_q  <= pend_pc_d;
      pc_r_q     <= pc_r_d;
      outs_cnt_q <= outs_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      halt_ack_q <= halt_ack_d;
    end
  end

endmodule
